mem_loader: RTL and testbench
=============================

# mem_loader

Byte-stream loader that fills instruction or data memory before the CPU runs. It is the initiator that drives the memory's `clk`/`regWE`/`Addr`/`DataIn` write port. It accepts bytes over a valid/ready handshake and packs each group of four into a little-endian 32-bit word. Each word is written with a one-cycle `regWE` strobe to consecutive byte addresses (stride 4), and the block flags completion after a fixed word count.

## Interface
- `ADDR_BASE`, default 0: byte address of the first word written.
- `ADDR_STEP`, default 4: address increment per word.
- `WORD_COUNT`, default 16: number of words loaded per run (32-bit unsigned).
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: pulse that begins a load run. It is honoured only in IDLE or DONE.
- `in_valid`  in  1: `in_byte` holds a valid byte.
- `in_byte`  in  8: stream byte.
- `in_ready`  out  1: loader accepts a byte this cycle.
- `regWE`  out  1: memory write strobe, high for exactly one cycle per word.
- `Addr`  out  32: memory byte address.
- `DataIn`  out  32: memory write data.
- `busy`  out  1: high in LOAD and WRITE.
- `done`  out  1: high in DONE.

## Operation
- A byte is accepted on a rising edge where `in_valid && in_ready`.
- States: IDLE, LOAD, WRITE, DONE.
- **IDLE**
  - `in_ready`=0.
  - On `start`: `Addr`←ADDR_BASE, byte_cnt←0, word_cnt←0, then go to LOAD.
  - If WORD_COUNT==0, `start` goes directly to DONE with no writes.
- **LOAD**
  - `in_ready`=1.
  - The accepted byte k (k=0..3) goes into word buffer bits [8k+7:8k].
  - byte_cnt increments modulo 4.
  - When the 4th byte is accepted: `DataIn`←assembled word, `regWE`←1, go to WRITE.
  - While `in_valid`=0, state is held indefinitely.
- **WRITE** (one cycle)
  - `in_ready`=0. `regWE`=1, with `Addr` and `DataIn` stable for the whole cycle.
  - On exit: `regWE`←0, `Addr`←`Addr`+ADDR_STEP, word_cnt←word_cnt+1.
  - If word_cnt+1==WORD_COUNT, go to DONE; otherwise go to LOAD.
- **DONE**
  - `done`=1 and `in_ready`=0.
  - `Addr` holds the last written address + ADDR_STEP.
  - `start` restarts exactly as from IDLE.
- `start` in LOAD or WRITE is ignored.
- Address arithmetic is 32-bit, modulo 2^32: it wraps silently and never saturates.
- `DataIn` holds its last value outside WRITE. `regWE` is never high outside WRITE.

## Timing
- Reset values: `in_ready`=0, `regWE`=0, `Addr`=ADDR_BASE, `DataIn`=0, `busy`=0, `done`=0, state IDLE, counters 0, word buffer 0.
- All outputs are registered. `in_ready` is a function of state only, with no combinational path from `in_valid`.
- `start` sampled at edge N makes `in_ready`=1 after edge N.
- 4th byte accepted at edge M gives `regWE`=1 from edge M to edge M+1. `Addr` and `DataIn` take their write values on edge M, the same edge that raises `regWE`.
- Throughput: minimum 5 cycles per word (4 accept cycles + 1 WRITE cycle).
- `done` rises on the edge that ends the final WRITE.
- Reset mid-operation (any state):
  - Immediate return to reset values; the partial word is discarded.
  - If reset asserts during WRITE, `regWE` drops asynchronously.
- Simultaneous `start` and `in_valid` in IDLE/DONE: the byte is not accepted (`in_ready`=0 that cycle).

## Configuration
- Macro `LOADER_CHECKSUM_EN`.
- When defined:
  - Adds output `checksum` (out, 32): XOR of every word written in the current run.
  - Cleared to 0 on reset and on an honoured `start`; updated on exit from WRITE.
  - Valid when `done`=1.
- When undefined: the port and its logic are absent, and behaviour is otherwise identical.

## Test plan
- Reset: assert `reset` asynchronously mid-cycle -> all outputs at reset values immediately; `Addr`=ADDR_BASE.
- Basic load (WORD_COUNT=2, base 0), stream 78 56 34 12 EF BE AD DE back-to-back -> write 0x12345678 at `Addr` 0, then 0xDEADBEEF at `Addr` 4; `regWE` high one cycle each; 10 cycles from first accept to `done`=1; final `Addr`=8.
- Stalls: same bytes with `in_valid` gaps of 1–3 cycles -> identical writes; no extra `regWE` pulses; state held during gaps.
- Reset mid-word: after 2 bytes accepted, pulse `reset`, then restart and send 4 bytes 01 02 03 04 -> no write before reset; one write of 0x04030201 at ADDR_BASE.
- Control: `start` during LOAD -> ignored, counters unchanged. `start` in DONE -> new run at ADDR_BASE. WORD_COUNT=0 -> DONE with zero writes.
- With `LOADER_CHECKSUM_EN`, the basic-load stream -> `checksum`=0xCC99E897 at `done`; 0 after the next `start`.

Source files
------------

// File: rtl/mem_loader.sv
// rtl/mem_loader.sv - byte-stream loader that fills a memory through its write port
//
// Accepts bytes over a valid/ready handshake and packs each group of four,
// little-endian, into a 32-bit word. Each word is written with a one-cycle
// regWE strobe at ADDR_BASE + n*ADDR_STEP. The block reports done after
// WORD_COUNT words have been written.
//
// Optional feature: define LOADER_CHECKSUM_EN to add the checksum output,
// which is the XOR of every word written in the current run.
//
// Ports:
//   clk       in   1   single clock, rising edge
//   reset     in   1   asynchronous, active-high
//   start     in   1   begin a run (honoured in IDLE or DONE only)
//   in_valid  in   1   in_byte holds a valid byte
//   in_byte   in   8   stream byte
//   in_ready  out  1   loader accepts a byte this cycle
//   regWE     out  1   memory write strobe, one cycle per word
//   Addr      out  32  memory byte address
//   DataIn    out  32  memory write data
//   busy      out  1   high while loading or writing
//   done      out  1   high once the run is complete
//   checksum  out  32  (LOADER_CHECKSUM_EN only) XOR of words written this run
module mem_loader #(
  parameter logic [31:0] ADDR_BASE  = 32'd0,
  parameter logic [31:0] ADDR_STEP  = 32'd4,
  parameter logic [31:0] WORD_COUNT = 32'd16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  output logic        regWE,
  output logic [31:0] Addr,
  output logic [31:0] DataIn,
  output logic        busy,
  output logic        done
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [31:0] checksum
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] word_cnt_q, word_cnt_d;
  // Only bytes 0..2 need buffering; byte 3 goes straight into the word.
  logic [23:0] buf_q, buf_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        in_ready_q, in_ready_d;
  logic        we_q, we_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] chk_q, chk_d;
`endif

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    buf_d      = buf_q;
    addr_d     = addr_q;
    data_d     = data_q;
`ifdef LOADER_CHECKSUM_EN
    chk_d      = chk_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          addr_d     = ADDR_BASE;
          byte_cnt_d = 2'd0;
          word_cnt_d = 32'd0;
          buf_d      = 24'd0;
`ifdef LOADER_CHECKSUM_EN
          chk_d      = 32'd0;
`endif
          state_d    = (WORD_COUNT == 32'd0) ? S_DONE : S_LOAD;
        end
      end

      S_LOAD: begin
        if (in_valid) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0:    buf_d[7:0]   = in_byte;
            2'd1:    buf_d[15:8]  = in_byte;
            2'd2:    buf_d[23:16] = in_byte;
            default: begin
              data_d  = {in_byte, buf_q};
              state_d = S_WRITE;
            end
          endcase
        end
      end

      S_WRITE: begin
        addr_d     = addr_q + ADDR_STEP;
        word_cnt_d = word_cnt_q + 32'd1;
`ifdef LOADER_CHECKSUM_EN
        chk_d      = chk_q ^ data_q;
`endif
        state_d    = (word_cnt_q + 32'd1 == WORD_COUNT) ? S_DONE : S_LOAD;
      end

      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered from the next state so each one is a
    // plain flop with no combinational path from the inputs.
    in_ready_d = (state_d == S_LOAD);
    we_d       = (state_d == S_WRITE);
    busy_d     = (state_d == S_LOAD) || (state_d == S_WRITE);
    done_d     = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= 2'd0;
      word_cnt_q <= 32'd0;
      buf_q      <= 24'd0;
      addr_q     <= ADDR_BASE;
      data_q     <= 32'd0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      chk_q      <= 32'd0;
`endif
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      buf_q      <= buf_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      in_ready_q <= in_ready_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef LOADER_CHECKSUM_EN
      chk_q      <= chk_d;
`endif
    end
  end

  assign in_ready = in_ready_q;
  assign regWE    = we_q;
  assign Addr     = addr_q;
  assign DataIn   = data_q;
  assign busy     = busy_q;
  assign done     = done_q;
`ifdef LOADER_CHECKSUM_EN
  assign checksum = chk_q;
`endif

endmodule

// File: tb/tb_mem_loader.sv
// tb/tb_mem_loader.sv - directed self-checking bench for mem_loader
module tb_mem_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       in_valid;
  logic [7:0] in_byte;

  // u_a: two words from base 0; u_b: two words from a base that wraps;
  // u_z: zero-word run. All three see the same stimulus.
  logic        a_ready, a_we, a_busy, a_done;
  logic [31:0] a_addr, a_data;
  logic        b_ready, b_we, b_busy, b_done;
  logic [31:0] b_addr, b_data;
  logic        z_ready, z_we, z_busy, z_done;
  logic [31:0] z_addr, z_data;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] a_chk, b_chk, z_chk;
`endif

  int vectors = 0;
  int fails   = 0;
  int cyc     = 0;
  int wr_a    = 0;
  int wr_z    = 0;
  logic [31:0] log_addr [0:15];
  logic [31:0] log_data [0:15];
  int base, t0, t1;

  always #5 clk = ~clk;

  mem_loader #(.ADDR_BASE(32'd0), .ADDR_STEP(32'd4), .WORD_COUNT(32'd2)) u_a (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(a_ready), .regWE(a_we), .Addr(a_addr), .DataIn(a_data),
    .busy(a_busy), .done(a_done)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(a_chk)
`endif
  );

  mem_loader #(.ADDR_BASE(32'hFFFF_FFFC), .ADDR_STEP(32'd4), .WORD_COUNT(32'd2)) u_b (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(b_ready), .regWE(b_we), .Addr(b_addr), .DataIn(b_data),
    .busy(b_busy), .done(b_done)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(b_chk)
`endif
  );

  mem_loader #(.ADDR_BASE(32'd0), .ADDR_STEP(32'd4), .WORD_COUNT(32'd0)) u_z (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(z_ready), .regWE(z_we), .Addr(z_addr), .DataIn(z_data),
    .busy(z_busy), .done(z_done)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(z_chk)
`endif
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (a_we === 1'b1) begin
      log_addr[wr_a % 16] <= a_addr;
      log_data[wr_a % 16] <= a_data;
      wr_a <= wr_a + 1;
    end
    if (z_we === 1'b1) wr_z <= wr_z + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_byte  = b;
    n = 0;
    while (a_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) chk("ready_timeout", {31'd0, a_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
    tick(); tick();

    chk("rst_ready",  {31'd0, a_ready}, 32'd0);
    chk("rst_we",     {31'd0, a_we},    32'd0);
    chk("rst_addr",   a_addr,           32'd0);
    chk("rst_data",   a_data,           32'd0);
    chk("rst_busy",   {31'd0, a_busy},  32'd0);
    chk("rst_done",   {31'd0, a_done},  32'd0);
    chk("rst_addr_b", b_addr,           32'hFFFF_FFFC);
`ifdef LOADER_CHECKSUM_EN
    chk("rst_chk",    a_chk,            32'd0);
`endif
    reset = 1'b0;
    tick();

    // start with a byte offered in the same cycle: that byte must be dropped
    start = 1'b1; in_valid = 1'b1; in_byte = 8'hAA;
    tick();
    start = 1'b0; in_valid = 1'b0;
    chk("start_ready", {31'd0, a_ready}, 32'd1);
    chk("start_busy",  {31'd0, a_busy},  32'd1);
    chk("z_done",      {31'd0, z_done},  32'd1);
    chk("z_busy",      {31'd0, z_busy},  32'd0);
    chk("z_addr",      z_addr,           32'd0);

    // basic back-to-back load
    base = wr_a;
    send_byte(8'h78, 0); t0 = cyc;
    send_byte(8'h56, 0);
    send_byte(8'h34, 0);
    send_byte(8'h12, 0);
    chk("w0_we",     {31'd0, a_we},    32'd1);
    chk("w0_addr",   a_addr,           32'd0);
    chk("w0_data",   a_data,           32'h1234_5678);
    chk("w0_ready",  {31'd0, a_ready}, 32'd0);
    chk("w0_addr_b", b_addr,           32'hFFFF_FFFC);
    tick();
    chk("w0x_we",    {31'd0, a_we},    32'd0);
    chk("w0x_addr",  a_addr,           32'd4);
    chk("w0x_data",  a_data,           32'h1234_5678);
    chk("w0x_ready", {31'd0, a_ready}, 32'd1);
    send_byte(8'hEF, 0);
    send_byte(8'hBE, 0);
    send_byte(8'hAD, 0);
    send_byte(8'hDE, 0);
    chk("w1_we",     {31'd0, a_we}, 32'd1);
    chk("w1_addr",   a_addr,        32'd4);
    chk("w1_data",   a_data,        32'hDEAD_BEEF);
    chk("w1_addr_b", b_addr,        32'd0);
    tick(); t1 = cyc;
    chk("fin_done",    {31'd0, a_done},  32'd1);
    chk("fin_busy",    {31'd0, a_busy},  32'd0);
    chk("fin_we",      {31'd0, a_we},    32'd0);
    chk("fin_ready",   {31'd0, a_ready}, 32'd0);
    chk("fin_addr",    a_addr,           32'd8);
    chk("fin_addr_b",  b_addr,           32'd4);
    chk("fin_latency", t1 - t0 + 1,      32'd10);
    chk("fin_writes",  wr_a - base,      32'd2);
    chk("log0_addr",   log_addr[base % 16],       32'd0);
    chk("log1_addr",   log_addr[(base + 1) % 16], 32'd4);
`ifdef LOADER_CHECKSUM_EN
    chk("fin_chk",     a_chk,            32'hCC99_E897);
`endif

    // restart from DONE, stalled stream, start ignored mid-word
    start = 1'b1; tick(); start = 1'b0;
    chk("re_done",  {31'd0, a_done},  32'd0);
    chk("re_addr",  a_addr,           32'd0);
    chk("re_ready", {31'd0, a_ready}, 32'd1);
`ifdef LOADER_CHECKSUM_EN
    chk("re_chk",   a_chk,            32'd0);
`endif
    base = wr_a;
    send_byte(8'h78, 1);
    send_byte(8'h56, 2);
    start = 1'b1; tick(); start = 1'b0;
    chk("mid_start_ready", {31'd0, a_ready}, 32'd1);
    chk("mid_start_addr",  a_addr,           32'd0);
    send_byte(8'h34, 3);
    in_valid = 1'b0;
    repeat (3) tick();
    chk("gap_ready", {31'd0, a_ready}, 32'd1);
    chk("gap_busy",  {31'd0, a_busy},  32'd1);
    chk("gap_we",    {31'd0, a_we},    32'd0);
    send_byte(8'h12, 0);
    chk("s0_we",   {31'd0, a_we}, 32'd1);
    chk("s0_data", a_data,        32'h1234_5678);
    tick();
    send_byte(8'hEF, 1);
    send_byte(8'hBE, 2);
    send_byte(8'hAD, 3);
    send_byte(8'hDE, 1);
    chk("s1_data", a_data, 32'hDEAD_BEEF);
    chk("s1_addr", a_addr, 32'd4);
    tick();
    chk("s_done",   {31'd0, a_done}, 32'd1);
    chk("s_addr",   a_addr,          32'd8);
    chk("s_writes", wr_a - base,     32'd2);
    chk("s_log0",   log_data[base % 16],       32'h1234_5678);
    chk("s_log1",   log_data[(base + 1) % 16], 32'hDEAD_BEEF);
`ifdef LOADER_CHECKSUM_EN
    chk("s_chk",    a_chk,           32'hCC99_E897);
`endif

    // reset mid-word, asserted between edges
    start = 1'b1; tick(); start = 1'b0;
    base = wr_a;
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    chk("mw_nowrite", wr_a - base, 32'd0);
    #3 reset = 1'b1;
    #1;
    chk("mw_ready", {31'd0, a_ready}, 32'd0);
    chk("mw_busy",  {31'd0, a_busy},  32'd0);
    chk("mw_addr",  a_addr,           32'd0);
    chk("mw_data",  a_data,           32'd0);
    tick(); reset = 1'b0;

    // reset during WRITE drops regWE without waiting for an edge
    start = 1'b1; tick(); start = 1'b0;
    send_byte(8'hA1, 0);
    send_byte(8'hA2, 0);
    send_byte(8'hA3, 0);
    send_byte(8'hA4, 0);
    chk("wr_rst_pre", {31'd0, a_we}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("wr_rst_we",  {31'd0, a_we}, 32'd0);
    chk("wr_rst_addr_b", b_addr, 32'hFFFF_FFFC);
    tick(); reset = 1'b0;

    // clean restart after reset
    start = 1'b1; tick(); start = 1'b0;
    base = wr_a;
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    send_byte(8'h03, 0);
    send_byte(8'h04, 0);
    chk("rr_data", a_data,        32'h0403_0201);
    chk("rr_addr", a_addr,        32'd0);
    chk("rr_we",   {31'd0, a_we}, 32'd1);
    tick();
    chk("rr_writes", wr_a - base,     32'd1);
    chk("rr_done",   {31'd0, a_done}, 32'd0);
    chk("rr_ready",  {31'd0, a_ready}, 32'd1);

    chk("z_writes", wr_z,             32'd0);
    chk("z_final",  {31'd0, z_done},  32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
